// File: rtl/pipe_pkg.sv
// Shared definitions for the per-stage opcode pipeline: opcode values,
// instruction field positions, the stage record and the pipeline FSM states.
package pipe_pkg;

   // Opcode map
   localparam logic [3:0] OP_NOP   = 4'b0000;
   localparam logic [3:0] OP_ATYPE = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_LBU   = 4'b0100;
   localparam logic [3:0] OP_SB    = 4'b0101;
   localparam logic [3:0] OP_LW    = 4'b0110;
   localparam logic [3:0] OP_SW    = 4'b0111;
   localparam logic [3:0] OP_JMP   = 4'b1011;
   localparam logic [3:0] OP_BLT   = 4'b1100;
   localparam logic [3:0] OP_BGT   = 4'b1101;
   localparam logic [3:0] OP_BEQ   = 4'b1110;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   // Opcode injected whenever a bubble enters a stage
   localparam logic [3:0] NOP_OP   = OP_NOP;

   // Field layout of a 16-bit instruction
   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RA_MSB = 11;
   localparam int RA_LSB = 8;
   localparam int RB_MSB = 7;
   localparam int RB_LSB = 4;
   localparam int FN_MSB = 3;
   localparam int FN_LSB = 0;

   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] funct;
   } stage_rec_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } pipe_state_t;

   localparam stage_rec_t NOP_REC = '{opcode: NOP_OP, ra: 4'd0, rb: 4'd0, funct: 4'd0};

   // Split a fetched instruction into its stage record
   function automatic stage_rec_t decode_instr(input logic [15:0] instr);
      stage_rec_t r;
      r.opcode = instr[OP_MSB:OP_LSB];
      r.ra     = instr[RA_MSB:RA_LSB];
      r.rb     = instr[RB_MSB:RB_LSB];
      r.funct  = instr[FN_MSB:FN_LSB];
      return r;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use interlock detector: flags when the load in EX writes a register
// that the instruction in ID reads. Register 0 never creates a dependency.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic [3:0] ex_opcode,
   input  logic [3:0] ex_ra,
   input  logic [3:0] id_ra,
   input  logic [3:0] id_rb,
   output logic       stall_req
);

   logic ex_is_load;

   // Compare the EX destination against both ID source fields
   always_comb begin
      ex_is_load = (ex_opcode == OP_LBU) || (ex_opcode == OP_LW);
      stall_req  = ex_is_load && (ex_ra != 4'd0) &&
                   ((ex_ra == id_ra) || (ex_ra == id_rb));
   end

endmodule

// File: rtl/stage_opcode_pipe.sv
// Per-stage opcode pipeline (ID/EX/MEM/WB) with bubble insertion for
// load-use stalls, taken-branch flushes and HALT drain/freeze.
// Optional feature macro: HAZARD_STALL_EN enables the load-use interlock;
// without it software must schedule load delay slots.
module stage_opcode_pipe
   import pipe_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_if,
   input  logic               instr_valid,
   input  logic               branch_taken,
   output logic [3:0]         opcode_id,
   output logic [3:0]         opcode_ex,
   output logic [3:0]         opcode_mem,
   output logic [3:0]         opcode_wb,
   output logic [3:0]         funct_wb,
   output logic [3:0]         ra_ex,
   output logic               pc_hold,
   output logic               halted
);

   stage_rec_t  id_p0, ex_p1, mem_p2, wb_p3;
   stage_rec_t  id_n, ex_n, mem_n, wb_n;
   pipe_state_t state, state_n;
   logic        stall_req;
   logic        drain;
   logic        frozen;
   logic        wb_unused;

   assign drain  = (state == DRAIN);
   assign frozen = (state == HALTED);

`ifdef HAZARD_STALL_EN
   load_use_detect u_load_use_detect (
      .ex_opcode (ex_p1.opcode),
      .ex_ra     (ex_p1.ra),
      .id_ra     (id_p0.ra),
      .id_rb     (id_p0.rb),
      .stall_req (stall_req)
   );
`else
   assign stall_req = 1'b0;
`endif

   // Next stage contents: freeze > flush > load-use bubble > normal advance
   always_comb begin
      id_n  = id_p0;
      ex_n  = ex_p1;
      mem_n = mem_p2;
      wb_n  = wb_p3;
      if (!frozen) begin
         wb_n  = mem_p2;
         mem_n = ex_p1;
         if (branch_taken) begin
            id_n = NOP_REC;
            ex_n = NOP_REC;
         end else if (stall_req) begin
            ex_n = NOP_REC;
         end else begin
            ex_n = id_p0;
            id_n = (drain || !instr_valid) ? NOP_REC : decode_instr(instr_if);
         end
      end
   end

   // ---- stage boundary: ID -> EX -> MEM -> WB registers ----
   // Advance the stage records every cycle with the values chosen above
   always_ff @(posedge clk) begin
      if (reset) begin
         id_p0  <= NOP_REC;
         ex_p1  <= NOP_REC;
         mem_p2 <= NOP_REC;
         wb_p3  <= NOP_REC;
      end else begin
         id_p0  <= id_n;
         ex_p1  <= ex_n;
         mem_p2 <= mem_n;
         wb_p3  <= wb_n;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= RUN;
      else       state <= state_n;
   end

   // Next state follows where HALT sits after this edge; HALTED is terminal
   always_comb begin
      state_n = state;
      case (state)
         HALTED: state_n = HALTED;
         default: begin
            if (wb_n.opcode == OP_HALT)
               state_n = HALTED;
            else if ((id_n.opcode == OP_HALT) || (ex_n.opcode == OP_HALT) ||
                     (mem_n.opcode == OP_HALT))
               state_n = DRAIN;
            else
               state_n = RUN;
         end
      endcase
   end

   // Fetch hold: always while frozen; a taken branch redirects fetch instead
   always_comb begin
      halted  = frozen;
      pc_hold = frozen || (!branch_taken && (drain || stall_req));
   end

   assign opcode_id  = id_p0.opcode;
   assign opcode_ex  = ex_p1.opcode;
   assign opcode_mem = mem_p2.opcode;
   assign opcode_wb  = wb_p3.opcode;
   assign funct_wb   = wb_p3.funct;
   assign ra_ex      = ex_p1.ra;

   // Register fields of the WB record have no consumer downstream
   assign wb_unused = ^{wb_p3.ra, wb_p3.rb};

endmodule

// File: tb/tb_stage_opcode_pipe.sv
// Directed bench for stage_opcode_pipe: a vector table for plain flow plus
// hand-written sequences for stall, flush, halt squash and halt freeze.
module tb_stage_opcode_pipe;

`ifdef HAZARD_STALL_EN
   localparam bit HAZ = 1'b1;
`else
   localparam bit HAZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr_if;
   logic        instr_valid;
   logic        branch_taken;
   logic [3:0]  opcode_id, opcode_ex, opcode_mem, opcode_wb, funct_wb, ra_ex;
   logic        pc_hold, halted;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] ins;
      logic        v;
      logic        br;
      logic [3:0]  id, ex, mem, wb, fwb, raex;
      logic        ph, h;
   } vec_t;

   vec_t tbl [9];

   always #5 clk = ~clk;

   stage_opcode_pipe dut (
      .clk          (clk),
      .reset        (reset),
      .instr_if     (instr_if),
      .instr_valid  (instr_valid),
      .branch_taken (branch_taken),
      .opcode_id    (opcode_id),
      .opcode_ex    (opcode_ex),
      .opcode_mem   (opcode_mem),
      .opcode_wb    (opcode_wb),
      .funct_wb     (funct_wb),
      .ra_ex        (ra_ex),
      .pc_hold      (pc_hold),
      .halted       (halted)
   );

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Apply inputs for one edge, then return them to idle before sampling
   task automatic step(input logic [15:0] ins, input logic v, input logic br);
      instr_if     = ins;
      instr_valid  = v;
      branch_taken = br;
      @(posedge clk);
      #1;
      instr_if     = 16'h0000;
      instr_valid  = 1'b0;
      branch_taken = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      //           ins       v     br    id    ex    mem   wb    fwb   raex  ph    h
      tbl[0] = '{16'h1234, 1'b1, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[1] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0};
      tbl[2] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[3] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h4, 4'h0, 1'b0, 1'b0};
      tbl[4] = '{16'h6010, 1'b1, 1'b0, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[5] = '{16'h1000, 1'b1, 1'b0, 4'h1, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[6] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h1, 4'h6, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[7] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h6, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[8] = '{16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0};

      reset        = 1'b1;
      instr_if     = 16'h0000;
      instr_valid  = 1'b0;
      branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset id", opcode_id, 4'h0);
      check("reset wb", opcode_wb, 4'h0);
      check("reset funct_wb", funct_wb, 4'h0);
      check("reset pc_hold", pc_hold, 1'b0);
      check("reset halted", halted, 1'b0);
      reset = 1'b0;

      // Plain flow and rA=0 load (never an interlock)
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].ins, tbl[i].v, tbl[i].br);
         check($sformatf("vec%0d id", i),      opcode_id,  tbl[i].id);
         check($sformatf("vec%0d ex", i),      opcode_ex,  tbl[i].ex);
         check($sformatf("vec%0d mem", i),     opcode_mem, tbl[i].mem);
         check($sformatf("vec%0d wb", i),      opcode_wb,  tbl[i].wb);
         check($sformatf("vec%0d funct", i),   funct_wb,   tbl[i].fwb);
         check($sformatf("vec%0d ra_ex", i),   ra_ex,      tbl[i].raex);
         check($sformatf("vec%0d pc_hold", i), pc_hold,    tbl[i].ph);
         check($sformatf("vec%0d halted", i),  halted,     tbl[i].h);
      end

      // LW r3 then dependent ATYPE
      idle(4);
      step(16'h6310, 1'b1, 1'b0);
      step(16'h1032, 1'b1, 1'b0);
      check("lu ra_ex", ra_ex, 4'h3);
      check("lu pc_hold", pc_hold, HAZ);
      step(16'h0000, 1'b0, 1'b0);
      check("lu ex", opcode_ex, HAZ ? 4'h0 : 4'h1);
      check("lu id", opcode_id, HAZ ? 4'h1 : 4'h0);
      check("lu pc_hold after", pc_hold, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
      check("lu wb +5", opcode_wb, HAZ ? 4'h0 : 4'h1);
      step(16'h0000, 1'b0, 1'b0);
      check("lu wb +6", opcode_wb, HAZ ? 4'h1 : 4'h0);

`ifdef HAZARD_STALL_EN
      // Back-to-back dependent loads stall once each
      idle(4);
      step(16'h6310, 1'b1, 1'b0);
      step(16'h6430, 1'b1, 1'b0);
      check("b2b stall1", pc_hold, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("b2b release1", pc_hold, 1'b0);
      check("b2b id held", opcode_id, 4'h6);
      check("b2b bubble1", opcode_ex, 4'h0);
      step(16'h1040, 1'b1, 1'b0);
      check("b2b stall2", pc_hold, 1'b1);
      step(16'h0000, 1'b0, 1'b0);
      check("b2b bubble2", opcode_ex, 4'h0);
      check("b2b id held2", opcode_id, 4'h1);
      step(16'h0000, 1'b0, 1'b0);
      check("b2b ex atype", opcode_ex, 4'h1);
`endif

      // Taken BEQ in EX flushes ID and EX
      idle(4);
      step(16'hE120, 1'b1, 1'b0);
      step(16'h1111, 1'b1, 1'b0);
      check("br ex beq", opcode_ex, 4'hE);
      step(16'h1222, 1'b1, 1'b1);
      check("br id", opcode_id, 4'h0);
      check("br ex", opcode_ex, 4'h0);
      check("br mem", opcode_mem, 4'hE);
      check("br pc_hold", pc_hold, 1'b0);
      step(16'h0000, 1'b0, 1'b0);
      check("br wb", opcode_wb, 4'hE);

      // HALT in ID squashed by taken BLT in EX
      idle(4);
      step(16'hC000, 1'b1, 1'b0);
      step(16'hF000, 1'b1, 1'b0);
      check("sq drain pc_hold", pc_hold, 1'b1);
      check("sq id halt", opcode_id, 4'hF);
      check("sq ex blt", opcode_ex, 4'hC);
      step(16'h1333, 1'b1, 1'b1);
      check("sq id", opcode_id, 4'h0);
      check("sq ex", opcode_ex, 4'h0);
      check("sq mem", opcode_mem, 4'hC);
      check("sq pc_hold", pc_hold, 1'b0);
      check("sq halted", halted, 1'b0);
      step(16'h1444, 1'b1, 1'b0);
      check("sq run id", opcode_id, 4'h1);

      // HALT drain, freeze and reset
      idle(4);
      step(16'hF000, 1'b1, 1'b0);
      check("h1 id", opcode_id, 4'hF);
      check("h1 pc_hold", pc_hold, 1'b1);
      step(16'h1555, 1'b1, 1'b0);
      check("h2 id nop", opcode_id, 4'h0);
      check("h2 ex", opcode_ex, 4'hF);
      check("h2 pc_hold", pc_hold, 1'b1);
      step(16'h1666, 1'b1, 1'b0);
      check("h3 mem", opcode_mem, 4'hF);
      check("h3 halted", halted, 1'b0);
      check("h3 pc_hold", pc_hold, 1'b1);
      step(16'h1777, 1'b1, 1'b0);
      check("h4 wb", opcode_wb, 4'hF);
      check("h4 halted", halted, 1'b1);
      check("h4 id", opcode_id, 4'h0);
      check("h4 mem", opcode_mem, 4'h0);
      step(16'h1888, 1'b1, 1'b1);
      check("frz wb", opcode_wb, 4'hF);
      check("frz id", opcode_id, 4'h0);
      check("frz halted", halted, 1'b1);
      check("frz pc_hold", pc_hold, 1'b1);
      step(16'h1999, 1'b1, 1'b0);
      check("frz2 wb", opcode_wb, 4'hF);
      check("frz2 id", opcode_id, 4'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst wb", opcode_wb, 4'h0);
      check("rst halted", halted, 1'b0);
      check("rst pc_hold", pc_hold, 1'b0);
      step(16'h1234, 1'b1, 1'b0);
      check("rst run id", opcode_id, 4'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stage_opcode_pipe.md
# stage_opcode_pipe

Producer side of the per-stage opcode bus: accepts fetched 16-bit instructions and advances their opcode and function fields through ID, EX, MEM and WB. It drives the stage opcodes and the WB function code consumed by the control unit. It also owns bubble insertion, which covers load-use stall, branch/jump flush and halt drain. It sits between instruction fetch and the control unit, and drives the PC-hold signal back to fetch.

## Interface
- INSTR_W, 16, instruction width; the field layout below is fixed for 16.
- NOP_OP, 4'b0000, opcode injected for bubbles.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr_if  in  16  fetched instruction: [15:12] opcode, [11:8] rA (dest/src1), [7:4] rB (src2/base), [3:0] function code.
- instr_valid  in  1  instr_if is meaningful this cycle; when low, a NOP enters ID.
- branch_taken  in  1  branch or jump in EX resolved taken this cycle.
- opcode_id, opcode_ex, opcode_mem, opcode_wb  out  4  stage opcodes.
- funct_wb  out  4  function code of the WB instruction.
- ra_ex  out  4  rA of the EX instruction, for forwarding.
- pc_hold  out  1  fetch must not advance PC this cycle (combinational).
- halted  out  1  sticky, set when HALT reaches WB.

## Operation
- Opcodes: NOP 0000, ATYPE 0001, AND 0010, OR 0011, LBU 0100, SB 0101, LW 0110, SW 0111, JMP 1011, BLT 1100, BGT 1101, BEQ 1110, HALT 1111.
- Stage registers hold {opcode, rA, rB, funct} for ID, EX, MEM and WB. On every non-frozen edge: WB<=MEM, MEM<=EX, and EX<=ID unless a bubble is inserted. ID loads instr_if when instr_valid=1, and loads NOP otherwise.
- Load-use stall:
  - Condition: opcode_ex ∈ {LBU, LW}, ra_ex ≠ 0, and ra_ex equals rA or rB of ID.
  - Effect: ID holds, EX<=NOP, pc_hold=1 for exactly one cycle.
- Flush: branch_taken=1 makes ID<=NOP and EX<=NOP on the next edge. The taken branch itself advances to MEM. pc_hold=0, because fetch redirects.
- Priority: reset > freeze > branch_taken > load-use stall > normal advance.
- Halt drain:
  - While opcode_id, opcode_ex or opcode_mem is HALT, ID loads NOP regardless of instr_valid, and pc_hold=1.
  - A HALT squashed by branch_taken ends the drain.
- Freeze: while halted=1 (HALT in WB, or already halted), no stage register changes and pc_hold=1. The WB contents remain HALT.
- State machine: RUN → DRAIN (HALT in ID/EX/MEM) → HALTED (HALT in WB). DRAIN → RUN on flush of the HALT. HALTED exits only on reset.

## Timing
- Reset values: all opcodes NOP, rA/rB/funct 0, funct_wb 0, ra_ex 0, pc_hold 0, halted 0, state RUN.
- Latency: instruction at instr_if in cycle n appears on opcode_id at n+1, opcode_ex at n+2, opcode_mem at n+3, and opcode_wb at n+4, absent stalls.
- Each load-use stall adds exactly one cycle. Back-to-back dependent loads stall once each.
- halted rises on the edge that moves HALT into WB.
- Reset mid-stall or mid-drain clears everything on the same edge.

## Configuration
- HAZARD_STALL_EN:
  - Defined: load-use detection as above.
  - Undefined: no interlock. pc_hold is driven only by drain/halt, and software schedules load delay slots.

## Structure
- pipe_pkg holds:
  - opcode localparams;
  - NOP_OP;
  - instruction field bit positions;
  - a stage-record struct {opcode, rA, rB, funct};
  - the state enum {RUN, DRAIN, HALTED}.
- One sub-module, load_use_detect: combinational compare of the ID and EX records, producing stall_req. It is instantiated only under HAZARD_STALL_EN.

## Test plan
- Reset, then ATYPE 0x1234 valid for 1 cycle → opcode_id=0001 at +1, opcode_wb=0001 with funct_wb=4 at +4.
- LW 0x6310, then ATYPE 0x1032 → pc_hold=1 for one cycle, opcode_ex=0000 bubble, and ATYPE reaches WB at +6 instead of +5.
- LW with rA=0 followed by a dependent ATYPE → no stall. With HAZARD_STALL_EN undefined, a dependent pair → no stall.
- BEQ in EX with branch_taken=1 → next cycle opcode_id=0000 and opcode_ex=0000, opcode_mem=1110.
- HALT 0xF000 followed by valid ATYPEs → ID fills with NOPs, pc_hold=1, halted=1 at +4, and stages frozen thereafter. Reset clears all of it.
- HALT in ID while BLT in EX takes the branch → HALT squashed, state returns to RUN, and pc_hold drops.
